// File: rtl/uart_rx_frontend_pkg.sv
// Shared UART receive definitions: state encoding, default bit timing, mid-bit helper.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package uart_rx_frontend_pkg;

   localparam int unsigned CLK_HZ           = 25_000_000;
   localparam int unsigned BAUD             = 115_200;
   // 217 clocks per bit at the defaults above
   localparam int unsigned DEF_CLKS_PER_BIT = CLK_HZ / BAUD;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_START = 3'd1,
      ST_DATA  = 3'd2,
      ST_STOP  = 3'd3,
      ST_BREAK = 3'd4
   } rx_state_t;

   // Count value at which the start bit is re-checked; it also places every
   // later sample near the middle of its bit.
   function automatic int unsigned half_bit(input int unsigned clks_per_bit);
      return (clks_per_bit - 1) / 2;
   endfunction

endpackage

// File: rtl/uart_rx_frontend_sync2.sv
// Two-flop synchroniser for an asynchronous pad input, reset to a chosen level.
// Latency: 2 clocks from pad to o_q.
// Backpressure: none (free-running sampler).
//
// Ports: i_clk core clock; i_resetn async active-low reset; i_d async input;
//        o_q synchronised output (RST_VAL while in reset).
module uart_rx_frontend_sync2 #(
   parameter bit RST_VAL = 1'b1
) (
   input  logic i_clk,
   input  logic i_resetn,
   input  logic i_d,
   output logic o_q
);

   logic r_meta;
   logic r_sync;

   always_ff @(posedge i_clk or negedge i_resetn) begin
      if (!i_resetn) begin
         r_meta <= RST_VAL;
         r_sync <= RST_VAL;
      end else begin
         r_meta <= i_d;
         r_sync <= r_meta;
      end
   end

   assign o_q = r_sync;

endmodule

// File: rtl/uart_rx_frontend.sv
// 8N1 UART receiver: oversamples rxd, delivers bytes through a one-entry valid/ready holding register.
// Latency: rx_valid rises 3 + H + 9*CLKS_PER_BIT clocks after the first clock that samples the start bit low.
// Backpressure: none on the line; a byte arriving while rx_valid is unconsumed overwrites it and sets overrun.
//
// Ports: clk core clock; resetn async active-low reset; rxd raw serial line (idle high);
//        rx_data/rx_valid/rx_ready byte handshake; frame_err, overrun sticky flags;
//        err_clr one-cycle pulse clearing both flags. CLKS_PER_BIT must be >= 8.
module uart_rx_frontend
   import uart_rx_frontend_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
   input  logic       clk,
   input  logic       resetn,
   input  logic       rxd,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   input  logic       rx_ready,
   output logic       frame_err,
   output logic       overrun,
   input  logic       err_clr
);

   localparam int unsigned CW = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] CNT_HALF = CW'(half_bit(CLKS_PER_BIT));
   localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);

   rx_state_t     r_state;
   rx_state_t     w_state_nxt;
   logic [CW-1:0] r_cnt;
   logic [2:0]    r_bit_idx;
   logic [7:0]    r_shift;
   logic [7:0]    r_rx_data;
   logic          r_rx_valid;
   logic          r_frame_err;
   logic          r_overrun;

   logic          w_rxs;
   logic          w_at_half;
   logic          w_at_last;
   logic          w_cnt_clr;
   logic          w_shift_en;
   logic          w_load;
   logic          w_fe_set;

   // Synchroniser resets high so a reset never looks like a start bit.
   uart_rx_frontend_sync2 #(.RST_VAL(1'b1)) u_sync (
      .i_clk    (clk),
      .i_resetn (resetn),
      .i_d      (rxd),
      .o_q      (w_rxs)
   );

   assign w_at_half = (r_cnt == CNT_HALF);
   assign w_at_last = (r_cnt == CNT_LAST);

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_clr   = 1'b0;
      w_shift_en  = 1'b0;
      w_load      = 1'b0;
      w_fe_set    = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (!w_rxs) begin
               w_state_nxt = ST_START;
               w_cnt_clr   = 1'b1;
            end
         end
         ST_START: begin
            // Re-check mid start bit; a high line here was only a glitch.
            if (w_at_half) begin
               w_cnt_clr   = 1'b1;
               w_state_nxt = w_rxs ? ST_IDLE : ST_DATA;
            end
         end
         ST_DATA: begin
            if (w_at_last) begin
               w_cnt_clr  = 1'b1;
               w_shift_en = 1'b1;
               if (r_bit_idx == 3'd7) begin
                  w_state_nxt = ST_STOP;
               end
            end
         end
         ST_STOP: begin
            if (w_at_last) begin
               w_cnt_clr = 1'b1;
               if (w_rxs) begin
                  w_load      = 1'b1;
                  w_state_nxt = ST_IDLE;
               end else begin
                  w_fe_set    = 1'b1;
                  w_state_nxt = ST_BREAK;
               end
            end
         end
         ST_BREAK: begin
            // Hold here until the line recovers so a long low is one error, not a stream of frames.
            if (w_rxs) begin
               w_cnt_clr   = 1'b1;
               w_state_nxt = ST_IDLE;
            end
         end
         default: begin
            w_cnt_clr   = 1'b1;
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   // Counter only runs in the timed states; it idles at zero elsewhere.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_cnt <= '0;
      end else if (w_cnt_clr || (r_state == ST_IDLE) || (r_state == ST_BREAK)) begin
         r_cnt <= '0;
      end else begin
         r_cnt <= r_cnt + CW'(1);
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_bit_idx <= 3'd0;
         r_shift   <= 8'h00;
      end else begin
         if (r_state == ST_START) begin
            r_bit_idx <= 3'd0;
         end else if (w_shift_en) begin
            r_bit_idx <= r_bit_idx + 3'd1;
         end
         if (w_shift_en) begin
            r_shift[r_bit_idx] <= w_rxs;
         end
      end
   end

   // A new byte beats a coincident consume; flag sets beat a coincident err_clr.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_rx_data   <= 8'h00;
         r_rx_valid  <= 1'b0;
         r_frame_err <= 1'b0;
         r_overrun   <= 1'b0;
      end else begin
         if (w_load) begin
            r_rx_data  <= r_shift;
            r_rx_valid <= 1'b1;
         end else if (r_rx_valid && rx_ready) begin
            r_rx_valid <= 1'b0;
         end

         if (w_load && r_rx_valid && !rx_ready) begin
            r_overrun <= 1'b1;
         end else if (err_clr) begin
            r_overrun <= 1'b0;
         end

         if (w_fe_set) begin
            r_frame_err <= 1'b1;
         end else if (err_clr) begin
            r_frame_err <= 1'b0;
         end
      end
   end

   assign rx_data   = r_rx_data;
   assign rx_valid  = r_rx_valid;
   assign frame_err = r_frame_err;
   assign overrun   = r_overrun;

endmodule

// File: tb/tb_uart_rx_frontend.sv
// Bench for uart_rx_frontend: directed scenarios plus randomized frames against a timestamp model.
// Latency: n/a.
// Backpressure: rx_ready driven by the scenarios / randomly.
module tb_uart_rx_frontend;

   localparam int CPB = 217;
   localparam int H   = (CPB - 1) / 2;
   localparam int M_SCAN  = 0;
   localparam int M_FRAME = 1;
   localparam int M_BRK   = 2;

   logic       clk      = 1'b0;
   logic       resetn   = 1'b0;
   logic       rxd      = 1'b1;
   logic       rx_ready = 1'b0;
   logic       err_clr  = 1'b0;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       frame_err;
   logic       overrun;

   int checks   = 0;
   int failures = 0;

   uart_rx_frontend #(.CLKS_PER_BIT(CPB)) dut (
      .clk       (clk),
      .resetn    (resetn),
      .rxd       (rxd),
      .rx_data   (rx_data),
      .rx_valid  (rx_valid),
      .rx_ready  (rx_ready),
      .frame_err (frame_err),
      .overrun   (overrun),
      .err_clr   (err_clr)
   );

   always #20 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got=0x%0h expected=0x%0h", name, got, exp);
      end
   endtask

   // ---------------- reference model ----------------
   // Works in absolute clock indices: a start is the first low sample while
   // scanning; every later sample is at a fixed offset from it, and results
   // appear two clocks after the deciding sample (synchroniser depth).
   logic [7:0] m_data  = 8'h00;
   logic       m_valid = 1'b0;
   logic       m_ferr  = 1'b0;
   logic       m_ovr   = 1'b0;
   int         mode      = M_SCAN;
   int         cyc       = 0;
   int         scan_from = 0;
   int         t0        = 0;
   int         ld_at     = -1;
   int         fe_at     = -1;
   logic [7:0] ld_byte   = 8'h00;
   logic [7:0] sh        = 8'h00;
   int         rel;
   int         k;

   always @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         m_data = 8'h00; m_valid = 1'b0; m_ferr = 1'b0; m_ovr = 1'b0;
         mode = M_SCAN; scan_from = cyc + 1; ld_at = -1; fe_at = -1;
      end else begin
         cyc++;
         if (ld_at == cyc) begin
            if (m_valid && !rx_ready) m_ovr = 1'b1;
            else if (err_clr) m_ovr = 1'b0;
            m_data  = ld_byte;
            m_valid = 1'b1;
         end else begin
            if (m_valid && rx_ready) m_valid = 1'b0;
            if (err_clr) m_ovr = 1'b0;
         end
         if (fe_at == cyc) m_ferr = 1'b1;
         else if (err_clr) m_ferr = 1'b0;

         case (mode)
            M_SCAN: begin
               if (cyc >= scan_from && rxd == 1'b0) begin
                  t0 = cyc;
                  mode = M_FRAME;
               end
            end
            M_FRAME: begin
               rel = cyc - t0 - 1 - H;
               if (rel == 0 && rxd == 1'b1) begin
                  mode = M_SCAN;
                  scan_from = cyc + 1;
               end else if (rel > 0 && (rel % CPB) == 0) begin
                  k = rel / CPB;
                  if (k <= 8) begin
                     sh[k-1] = rxd;
                  end else if (rxd) begin
                     ld_at = cyc + 2; ld_byte = sh;
                     mode = M_SCAN; scan_from = cyc + 1;
                  end else begin
                     fe_at = cyc + 2;
                     mode = M_BRK;
                  end
               end
            end
            default: begin
               if (rxd) begin
                  mode = M_SCAN;
                  scan_from = cyc + 1;
               end
            end
         endcase
      end
   end

   // ---------------- per-cycle compare ----------------
   logic       prev_v = 1'b0;
   logic [7:0] rise_dat[$];
   time        t_rise = 0;
   time        t_fall = 0;
   time        t_start = 0;

   always @(posedge rx_valid) t_rise = $time;
   always @(negedge rx_valid) t_fall = $time;

   always @(negedge clk) begin
      checks++;
      if ({rx_data, rx_valid, frame_err, overrun} !== {m_data, m_valid, m_ferr, m_ovr}) begin
         failures++;
         $display("FAIL model_cmp t=%0t: got data=%h v=%b fe=%b ov=%b, expected data=%h v=%b fe=%b ov=%b",
                  $time, rx_data, rx_valid, frame_err, overrun, m_data, m_valid, m_ferr, m_ovr);
      end
      if (rx_valid === 1'b1 && prev_v === 1'b0) rise_dat.push_back(rx_data);
      prev_v = rx_valid;
   end

   // ---------------- stimulus ----------------
   task automatic send_frame(input logic [7:0] b, input bit stop_ok, input int stop_clks);
      @(negedge clk);
      rxd = 1'b0;
      t_start = $time;
      repeat (CPB) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         rxd = b[i];
         repeat (CPB) @(negedge clk);
      end
      rxd = stop_ok;
      repeat (stop_clks) @(negedge clk);
      if (!stop_ok) begin
         rxd = 1'b1;
         repeat (CPB) @(negedge clk);
      end
   endtask

   task automatic pulse(input bit rdy, input bit clr);
      @(negedge clk);
      rx_ready = rdy;
      err_clr  = clr;
      @(negedge clk);
      rx_ready = 1'b0;
      err_clr  = 1'b0;
   endtask

   bit done = 1'b0;
   int n0;
   int rises_before;

   initial begin
      repeat (3) @(negedge clk);
      #5 resetn = 1'b1;
      @(negedge clk);
      chk("reset_rx_data", rx_data, 8'h00);
      chk("reset_rx_valid", rx_valid, 1'b0);
      chk("reset_frame_err", frame_err, 1'b0);
      chk("reset_overrun", overrun, 1'b0);

      // single byte, latency
      rises_before = rise_dat.size();
      send_frame(8'h34, 1'b1, CPB);
      chk("lat_0x34_rises", rise_dat.size() - rises_before, 1);
      chk("lat_0x34_clocks", 32'((t_rise - t_start - 20) / 40), 2064);
      chk("data_0x34", rx_data, 8'h34);
      chk("valid_0x34", rx_valid, 1'b1);
      chk("flags_0x34", {frame_err, overrun}, 2'b00);
      pulse(1'b1, 1'b0);
      chk("consume_0x34", rx_valid, 1'b0);

      // overrun
      send_frame(8'h35, 1'b1, CPB);
      send_frame(8'h2A, 1'b1, CPB);
      chk("ovr_data", rx_data, 8'h2A);
      chk("ovr_valid", rx_valid, 1'b1);
      chk("ovr_flag", overrun, 1'b1);
      pulse(1'b0, 1'b1);
      chk("ovr_cleared", overrun, 1'b0);

      // framing error
      send_frame(8'h39, 1'b0, CPB);
      chk("fe_flag", frame_err, 1'b1);
      chk("fe_valid_kept", rx_valid, 1'b1);
      chk("fe_data_kept", rx_data, 8'h2A);
      pulse(1'b1, 1'b1);
      chk("fe_cleared", {rx_valid, frame_err}, 2'b00);
      send_frame(8'h2F, 1'b1, CPB);
      chk("after_fe_data", rx_data, 8'h2F);
      chk("after_fe_flags", {rx_valid, frame_err, overrun}, 3'b100);
      pulse(1'b1, 1'b0);

      // glitch rejection
      @(negedge clk);
      rxd = 1'b0;
      repeat (40) @(negedge clk);
      rxd = 1'b1;
      repeat (3 * CPB) @(negedge clk);
      chk("glitch_outputs", {rx_valid, frame_err, overrun}, 3'b000);
      chk("glitch_data", rx_data, 8'h2F);

      // reset mid bit 4
      fork
         send_frame(8'h33, 1'b1, CPB);
         begin
            repeat (1 + 5 * CPB + CPB / 2) @(negedge clk);
            #5 resetn = 1'b0;
         end
      join
      chk("midreset_outputs", {rx_data, rx_valid, frame_err, overrun}, 11'h000);
      @(negedge clk);
      #5 resetn = 1'b1;
      repeat (CPB) @(negedge clk);
      send_frame(8'h30, 1'b1, CPB);
      chk("after_reset_data", rx_data, 8'h30);
      chk("after_reset_valid", rx_valid, 1'b1);
      pulse(1'b1, 1'b0);

      // back-to-back with ready held high
      @(negedge clk);
      rx_ready = 1'b1;
      n0 = rise_dat.size();
      send_frame(8'h34, 1'b1, CPB);
      send_frame(8'h32, 1'b1, CPB);
      repeat (CPB) @(negedge clk);
      chk("b2b_pulses", rise_dat.size() - n0, 2);
      if (rise_dat.size() >= n0 + 2) begin
         chk("b2b_first", rise_dat[n0], 8'h34);
         chk("b2b_second", rise_dat[n0+1], 8'h32);
      end
      chk("b2b_width", 32'((t_fall - t_rise) / 40), 1);
      chk("b2b_no_ovr", overrun, 1'b0);
      rx_ready = 1'b0;

      // randomized traffic against the model
      fork
         begin
            for (int f = 0; f < 8; f++) begin
               if ($urandom_range(0, 5) == 0) begin
                  @(negedge clk);
                  rxd = 1'b0;
                  repeat ($urandom_range(3, 100)) @(negedge clk);
                  rxd = 1'b1;
                  repeat (2 * CPB) @(negedge clk);
               end
               send_frame(8'($urandom_range(0, 255)), $urandom_range(0, 7) != 0,
                          $urandom_range(H + 1, CPB));
               repeat ($urandom_range(0, 300)) @(negedge clk);
            end
            repeat (CPB) @(negedge clk);
            done = 1'b1;
         end
         begin
            while (!done) begin
               @(negedge clk);
               rx_ready = ($urandom_range(0, 3) == 0);
               err_clr  = ($urandom_range(0, 40) == 0);
            end
            rx_ready = 1'b0;
            err_clr  = 1'b0;
         end
      join

      repeat (4) @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/uart_rx_frontend.md
# uart_rx_frontend

Serial receive front end for the SoC UART: oversamples the asynchronous `RXD` pin, recovers 8N1 frames at 115200 baud from the 25 MHz core clock, and presents each byte in a one-entry holding register with a valid/ready handshake. Sits between the `RXD` pad and the memory-mapped UART register block that the CPU polls. Also flags framing errors and overruns.

## Interface
- `CLKS_PER_BIT`, 217, clocks per bit period (25 000 000 / 115 200); must be ≥ 8.
- `clk`  input  1  core clock, all logic on rising edge.
- `resetn`  input  1  asynchronous, active-low reset.
- `rxd`  input  1  raw serial line, idle high, asynchronous to `clk`.
- `rx_data`  output  8  last accepted byte, LSB first on the wire.
- `rx_valid`  output  1  `rx_data` holds an unconsumed byte.
- `rx_ready`  input  1  consumer takes the byte on a clock edge where `rx_valid & rx_ready`.
- `frame_err`  output  1  sticky: a stop bit was sampled low.
- `overrun`  output  1  sticky: a byte was accepted while `rx_valid` was still set.
- `err_clr`  input  1  single-cycle pulse; clears `frame_err` and `overrun`.

## Operation
- Reset values: `rx_data`=0x00, `rx_valid`=0, `frame_err`=0, `overrun`=0, FSM=IDLE, both synchroniser flops=1, counters=0.
- Two-flop synchroniser on `rxd`; the FSM sees only the synchronised signal `rxs`.
- Bit counter `cnt` of width clog2(CLKS_PER_BIT), cleared on every state entry. H = (CLKS_PER_BIT−1)/2 (108 at default).
- IDLE: `rxs`=0 → START.
- START: at `cnt`==H, sample `rxs`; 0 → DATA (bit index 0), 1 → IDLE (glitch rejected, no flags).
- DATA: at `cnt`==CLKS_PER_BIT−1, shift `rxs` into bit [index] of the shift register; index 7 → STOP, else index+1 and `cnt` restarts.
- STOP: at `cnt`==CLKS_PER_BIT−1, sample `rxs`:
  - 1: load `rx_data`, set `rx_valid`; if `rx_valid` was already set and not consumed this cycle, set `overrun` (new byte overwrites). → IDLE.
  - 0: set `frame_err`, do not load or touch `rx_valid`. → BREAK.
- BREAK: wait until `rxs`=1, then → IDLE (a held-low line yields exactly one `frame_err`, no phantom frames).
- Handshake: `rx_valid & rx_ready` at an edge clears `rx_valid` next cycle. If the same edge also loads a new byte, the load wins: `rx_valid` stays 1, `rx_data` updates, no overrun.
- `err_clr` coincident with a new error event: the set wins.
- `rx_ready` when `rx_valid`=0 is ignored.

## Timing
- Frame latency: `rx_valid` rises exactly 3 + H + 9·CLKS_PER_BIT clocks after the first rising edge of `clk` on which `rxd` is sampled low (2064 at default). This comprises 2 synchroniser flops, 1 IDLE→START, H, 8 data bits and 1 stop bit.
- Sample point is mid-bit ±1 clock. Tolerates ±2 % baud mismatch.
- Back-to-back frames: the next start bit is detected on the first clock after STOP returns to IDLE. The minimum stop length is H+1 clocks.
- `resetn` low mid-frame: immediate return to reset values, with the partial byte discarded. After release, a frame already in progress is only picked up at its next falling edge.
- All outputs are registered, with no combinational path from inputs.

## Structure
- `uart_defs.vh` holds the shared state encodings (IDLE, START, DATA, STOP, BREAK) and the default CLKS_PER_BIT / baud localparams. The TX side of the UART shares this file.
- Sub-module `sync2`: a parameterised-reset-value two-flop synchroniser, reused by other pad inputs.
- Estimated size is about 150–200 lines of RTL.

## Test plan
- Send 0x34 at 8680 ns/bit with `rx_ready`=0. Expect `rx_data`=0x34, `rx_valid`=1 at 2064 clocks after the start edge, and no flags. Then pulse `rx_ready`: `rx_valid`=0 the next cycle.
- Send 0x35 then 0x2A without `rx_ready`. Expect `rx_data`=0x2A, `rx_valid`=1, `overrun`=1. After an `err_clr` pulse, `overrun`=0.
- Send 0x39 with the stop bit forced low, then the line high. Expect `frame_err`=1, `rx_valid` unchanged and `rx_data` unchanged. Follow with 0x2F: it is received correctly.
- Drive `rxd` low for 40 clocks, then high. Expect no `rx_valid`, no flags, and the FSM back in IDLE.
- Assert `resetn` low midway through data bit 4 of 0x33. Expect all outputs to reset values with no `rx_valid`. The next clean 0x30 is received.
- Hold `rx_ready`=1 throughout while sending 0x34, 0x32 back-to-back with a 1-bit stop. Expect each byte to produce a 1-cycle `rx_valid` pulse with the correct data and no overrun.
